// File: rtl/rotary_edit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rotary_edit_ctrl
// Purpose  : Four-digit BCD value editor driven by a rotary encoder and one
//            push-button. A short press enters edit mode and then moves the
//            edit cursor. Rotation changes the selected digit. A long press
//            commits the edit; in view mode a long press clears the value.
//            An idle edit session is abandoned after a timeout. The block also
//            drives a multiplexed 4-digit display and blinks the selected
//            digit while editing.
// Ports    : clk          system clock, rising edge
//            rst          asynchronous reset, active low
//            step_cw      one-cycle pulse, one clockwise detent
//            step_ccw     one-cycle pulse, one counter-clockwise detent
//            key          debounced push-button level, 1 = pressed
//            tick_1ms     one-cycle strobe per millisecond
//            value        committed value, 4 BCD digits, [3:0] = digit 0
//            commit       one-cycle pulse, coincident with an updated value
//            edit_active  high while editing
//            digit_sel    index of the digit being edited
//            fnd_com      digit enables, active-low one-hot
//            fnd_bcd      BCD code of the scanned digit
//            fnd_blank    scanned digit must be dark
// Revision : 1.0 - initial release
// ============================================================================
module rotary_edit_ctrl #(
    parameter int LONG_MS    = 1000,
    parameter int TIMEOUT_MS = 5000,
    parameter int BLINK_MS   = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_cw,
    input  logic        step_ccw,
    input  logic        key,
    input  logic        tick_1ms,
    output logic [15:0] value,
    output logic        commit,
    output logic        edit_active,
    output logic [1:0]  digit_sel,
    output logic [3:0]  fnd_com,
    output logic [3:0]  fnd_bcd,
    output logic        fnd_blank
);

    localparam int c_hold_w  = $clog2(LONG_MS + 1);
    localparam int c_to_w    = $clog2(TIMEOUT_MS + 1);
    localparam int c_blink_w = $clog2(BLINK_MS + 1);

    localparam logic [c_hold_w-1:0]  c_long_cnt  = c_hold_w'(LONG_MS);
    localparam logic [c_to_w-1:0]    c_to_cnt    = c_to_w'(TIMEOUT_MS);
    localparam logic [c_blink_w-1:0] c_blink_end = c_blink_w'(BLINK_MS - 1);

    typedef enum logic [1:0] {
        ST_VIEW   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic                  key_q,       key_d;
    logic [c_hold_w-1:0]   hold_cnt_q,  hold_cnt_d;
    logic                  long_done_q, long_done_d;
    logic [c_to_w-1:0]     timeout_q,   timeout_d;
    logic [15:0]           value_q,     value_d;
    logic [15:0]           work_q,      work_d;
    logic                  commit_q,    commit_d;
    logic [1:0]            digit_sel_q, digit_sel_d;
    logic [1:0]            scan_idx_q,  scan_idx_d;
    logic [c_blink_w-1:0]  blink_cnt_q, blink_cnt_d;
    logic                  blink_off_q, blink_off_d;

    logic        w_key_rise;
    logic        w_key_fall;
    logic        w_long_evt;
    logic        w_short_evt;
    logic        w_activity;
    logic        w_blink_restart;
    logic [3:0]  w_cur_digit;
    logic [15:0] w_shown;

    function automatic logic [3:0] bcd_up(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dn(input logic [3:0] d);
        return ((d == 4'd0) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
    endfunction

    // Key event detection
    always_comb begin
        w_key_rise  = key & ~key_q;
        w_key_fall  = ~key & key_q;
        // long_done_q still belongs to the previous press in a rise cycle,
        // so the rise itself is excluded explicitly.
        w_long_evt  = key & ~w_key_rise & ~long_done_q & (hold_cnt_q == c_long_cnt);
        w_short_evt = w_key_fall & ~long_done_q;
        w_activity  = step_cw | step_ccw | w_key_rise | w_key_fall;

        key_d       = key;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q | w_long_evt;
        if (w_key_rise) begin
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if (key && tick_1ms && (hold_cnt_q != c_long_cnt)) begin
            hold_cnt_d  = hold_cnt_q + 1'b1;
        end
    end

    // Edit state machine
    always_comb begin
        state_d         = state_q;
        value_d         = value_q;
        work_d          = work_q;
        commit_d        = 1'b0;
        digit_sel_d     = digit_sel_q;
        timeout_d       = timeout_q;
        w_blink_restart = 1'b0;
        w_cur_digit     = work_q[{digit_sel_q, 2'b00} +: 4];

        case (state_q)
            ST_VIEW: begin
                timeout_d = '0;
                if (w_long_evt) begin
                    value_d  = 16'h0000;
                    commit_d = 1'b1;
                end else if (w_short_evt) begin
                    state_d         = ST_EDIT;
                    work_d          = value_q;
                    digit_sel_d     = 2'd0;
                    w_blink_restart = 1'b1;
                end
            end
            ST_EDIT: begin
                // Steps use the current digit_sel, so a step coinciding with
                // a key event lands on the digit selected before the event.
                if (step_cw && !step_ccw) begin
                    work_d[{digit_sel_q, 2'b00} +: 4] = bcd_up(w_cur_digit);
                end else if (step_ccw && !step_cw) begin
                    work_d[{digit_sel_q, 2'b00} +: 4] = bcd_dn(w_cur_digit);
                end

                if (w_activity) begin
                    timeout_d = '0;
                end else if (tick_1ms && (timeout_q != c_to_cnt)) begin
                    timeout_d = timeout_q + 1'b1;
                end

                if (w_long_evt) begin
                    state_d = ST_COMMIT;
                end else if (w_short_evt) begin
                    digit_sel_d = digit_sel_q + 2'd1;
                end else if (!w_activity && (timeout_q == c_to_cnt)) begin
                    state_d = ST_VIEW;
                end
            end
            ST_COMMIT: begin
                value_d   = work_q;
                commit_d  = 1'b1;
                timeout_d = '0;
                state_d   = ST_VIEW;
            end
            default: begin
                state_d = ST_VIEW;
            end
        endcase
    end

    // Display scan and blink
    always_comb begin
        scan_idx_d  = tick_1ms ? scan_idx_q + 2'd1 : scan_idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (w_blink_restart) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (tick_1ms) begin
            if (blink_cnt_q >= c_blink_end) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_VIEW;
            key_q       <= 1'b0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            timeout_q   <= '0;
            value_q     <= 16'h0000;
            work_q      <= 16'h0000;
            commit_q    <= 1'b0;
            digit_sel_q <= 2'd0;
            scan_idx_q  <= 2'd0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            timeout_q   <= timeout_d;
            value_q     <= value_d;
            work_q      <= work_d;
            commit_q    <= commit_d;
            digit_sel_q <= digit_sel_d;
            scan_idx_q  <= scan_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    always_comb begin
        value       = value_q;
        commit      = commit_q;
        edit_active = (state_q == ST_EDIT);
        digit_sel   = digit_sel_q;
        fnd_com     = ~(4'b0001 << scan_idx_q);
        w_shown     = edit_active ? work_q : value_q;
        fnd_bcd     = w_shown[{scan_idx_q, 2'b00} +: 4];
        fnd_blank   = edit_active & (scan_idx_q == digit_sel_q) & blink_off_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_rotary_edit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotary_edit_ctrl
// Purpose  : Self-checking bench for rotary_edit_ctrl. A table of operations
//            with expected results is pushed through a scoreboard queue,
//            followed by hand-written display-scan and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotary_edit_ctrl;

    localparam int LONG_MS    = 4;
    localparam int TIMEOUT_MS = 10;
    localparam int BLINK_MS   = 2;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        step_cw  = 1'b0;
    logic        step_ccw = 1'b0;
    logic        key      = 1'b0;
    logic        tick_1ms = 1'b0;
    logic [15:0] value;
    logic        commit;
    logic        edit_active;
    logic [1:0]  digit_sel;
    logic [3:0]  fnd_com;
    logic [3:0]  fnd_bcd;
    logic        fnd_blank;

    rotary_edit_ctrl #(
        .LONG_MS    (LONG_MS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .BLINK_MS   (BLINK_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step_cw     (step_cw),
        .step_ccw    (step_ccw),
        .key         (key),
        .tick_1ms    (tick_1ms),
        .value       (value),
        .commit      (commit),
        .edit_active (edit_active),
        .digit_sel   (digit_sel),
        .fnd_com     (fnd_com),
        .fnd_bcd     (fnd_bcd),
        .fnd_blank   (fnd_blank)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {
        OP_SHORT, OP_LONG, OP_CW, OP_CCW, OP_BOTH, OP_IDLE
    } op_t;

    typedef struct {
        op_t         op;
        int          arg;
        logic [15:0] exp_value;
        logic        exp_edit;
        logic [1:0]  exp_sel;
        int          exp_commits;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int tick_cnt   = 0;
    int commit_cnt = 0;
    int entry_tick = 0;

    // Count commit pulses (one per high cycle).
    always @(negedge clk) begin
        if (rst && commit) commit_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick;
        tick_1ms = 1'b1;
        cyc(1);
        tick_1ms = 1'b0;
        cyc(1);
        tick_cnt++;
    endtask

    task automatic short_press;
        key = 1'b1;
        cyc(1);
        do_tick();
        key = 1'b0;
        cyc(2);
    endtask

    task automatic long_press;
        key = 1'b1;
        cyc(1);
        repeat (LONG_MS) do_tick();
        cyc(2);
        key = 1'b0;
        cyc(3);
    endtask

    task automatic step(input logic cw, input logic ccw, input int n);
        repeat (n) begin
            step_cw  = cw;
            step_ccw = ccw;
            cyc(1);
            step_cw  = 1'b0;
            step_ccw = 1'b0;
            cyc(1);
        end
    endtask

    function automatic void add(input op_t op, input int arg, input logic [15:0] v,
                                input logic e, input logic [1:0] s, input int c);
        vec_t r;
        r.op = op; r.arg = arg; r.exp_value = v; r.exp_edit = e; r.exp_sel = s; r.exp_commits = c;
        vecs.push_back(r);
    endfunction

    task automatic apply(input vec_t r);
        case (r.op)
            OP_SHORT: repeat (r.arg) short_press();
            OP_LONG:  long_press();
            OP_CW:    step(1'b1, 1'b0, r.arg);
            OP_CCW:   step(1'b0, 1'b1, r.arg);
            OP_BOTH:  step(1'b1, 1'b1, r.arg);
            default:  begin repeat (r.arg) do_tick(); cyc(2); end
        endcase
    endtask

    initial begin
        vec_t exp_r;
        logic [3:0] work_dig [4];
        int idx;
        logic exp_off;

        // op, arg, value, edit, sel, commits
        add(OP_SHORT, 1, 16'h0000, 1'b1, 2'd0, 0);
        add(OP_CW,    3, 16'h0000, 1'b1, 2'd0, 0);
        add(OP_LONG,  1, 16'h0003, 1'b0, 2'd0, 1);
        add(OP_SHORT, 1, 16'h0003, 1'b1, 2'd0, 1);
        add(OP_CW,    6, 16'h0003, 1'b1, 2'd0, 1);
        add(OP_LONG,  1, 16'h0009, 1'b0, 2'd0, 2);
        add(OP_SHORT, 1, 16'h0009, 1'b1, 2'd0, 2);
        add(OP_CW,    1, 16'h0009, 1'b1, 2'd0, 2);
        add(OP_LONG,  1, 16'h0000, 1'b0, 2'd0, 3);
        add(OP_SHORT, 1, 16'h0000, 1'b1, 2'd0, 3);
        add(OP_SHORT, 2, 16'h0000, 1'b1, 2'd2, 3);
        add(OP_CCW,   1, 16'h0000, 1'b1, 2'd2, 3);
        add(OP_LONG,  1, 16'h0900, 1'b0, 2'd2, 4);
        add(OP_SHORT, 1, 16'h0900, 1'b1, 2'd0, 4);
        add(OP_CW,    1, 16'h0900, 1'b1, 2'd0, 4);
        add(OP_IDLE,  8, 16'h0900, 1'b1, 2'd0, 4);
        add(OP_IDLE,  4, 16'h0900, 1'b0, 2'd0, 4);
        add(OP_CW,    1, 16'h0900, 1'b0, 2'd0, 4);
        add(OP_SHORT, 1, 16'h0900, 1'b1, 2'd0, 4);
        add(OP_IDLE,  6, 16'h0900, 1'b1, 2'd0, 4);
        add(OP_BOTH,  1, 16'h0900, 1'b1, 2'd0, 4);
        add(OP_IDLE,  6, 16'h0900, 1'b1, 2'd0, 4);
        add(OP_LONG,  1, 16'h0900, 1'b0, 2'd0, 5);
        add(OP_LONG,  1, 16'h0000, 1'b0, 2'd0, 6);
        add(OP_SHORT, 1, 16'h0000, 1'b1, 2'd0, 6);
        add(OP_SHORT, 3, 16'h0000, 1'b1, 2'd3, 6);
        add(OP_SHORT, 1, 16'h0000, 1'b1, 2'd0, 6);
        add(OP_CCW,   1, 16'h0000, 1'b1, 2'd0, 6);
        add(OP_LONG,  1, 16'h0009, 1'b0, 2'd0, 7);

        // Reset state
        cyc(3);
        check("rst_value",  {16'd0, value}, 32'h0000);
        check("rst_commit", {31'd0, commit}, 32'd0);
        check("rst_edit",   {31'd0, edit_active}, 32'd0);
        check("rst_sel",    {30'd0, digit_sel}, 32'd0);
        check("rst_com",    {28'd0, fnd_com}, 32'hE);
        check("rst_bcd",    {28'd0, fnd_bcd}, 32'd0);
        check("rst_blank",  {31'd0, fnd_blank}, 32'd0);
        rst = 1'b1;
        cyc(2);

        // Table through scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            sb_q.push_back(vecs[i]);
            apply(vecs[i]);
            exp_r = sb_q.pop_front();
            check($sformatf("v%0d_value", i),   {16'd0, value}, {16'd0, exp_r.exp_value});
            check($sformatf("v%0d_edit", i),    {31'd0, edit_active}, {31'd0, exp_r.exp_edit});
            if (exp_r.exp_edit)
                check($sformatf("v%0d_sel", i), {30'd0, digit_sel}, {30'd0, exp_r.exp_sel});
            check($sformatf("v%0d_commits", i), commit_cnt, exp_r.exp_commits);
        end

        // Display scan and blink while editing digit 1; value is 0009 here.
        short_press();
        entry_tick = tick_cnt;
        step(1'b1, 1'b0, 2);          // digit 0: 9 -> 0 -> 1
        short_press();                // select digit 1
        step(1'b1, 1'b0, 2);          // digit 1: 0 -> 2
        work_dig[0] = 4'd1; work_dig[1] = 4'd2; work_dig[2] = 4'd0; work_dig[3] = 4'd0;
        check("scan_sel", {30'd0, digit_sel}, 32'd1);
        for (int t = 0; t < 8; t++) begin
            do_tick();
            idx     = tick_cnt % 4;
            exp_off = (((tick_cnt - entry_tick) / BLINK_MS) % 2) == 1;
            check($sformatf("scan%0d_com", t),   {28'd0, fnd_com}, {28'd0, ~(4'b0001 << idx)});
            check($sformatf("scan%0d_bcd", t),   {28'd0, fnd_bcd}, {28'd0, work_dig[idx]});
            check($sformatf("scan%0d_blank", t), {31'd0, fnd_blank}, {31'd0, (idx == 1) && exp_off});
        end
        check("scan_edit", {31'd0, edit_active}, 32'd1);

        // Reset in the middle of an edit
        rst = 1'b0;
        #2;
        check("mid_rst_value", {16'd0, value}, 32'h0000);
        check("mid_rst_edit",  {31'd0, edit_active}, 32'd0);
        check("mid_rst_com",   {28'd0, fnd_com}, 32'hE);
        check("mid_rst_blank", {31'd0, fnd_blank}, 32'd0);
        tick_1ms = 1'b1;
        cyc(2);
        tick_1ms = 1'b0;
        check("mid_rst_bcd", {28'd0, fnd_bcd}, 32'd0);
        check("mid_rst_commit", {31'd0, commit}, 32'd0);
        rst = 1'b1;
        tick_cnt = 0;
        cyc(3);
        check("post_rst_commits", commit_cnt, 7);
        check("post_rst_edit", {31'd0, edit_active}, 32'd0);
        check("post_rst_com",  {28'd0, fnd_com}, 32'hE);

        // Working copy from before reset must not come back.
        short_press();
        long_press();
        check("post_rst_value",   {16'd0, value}, 32'h0000);
        check("post_rst_commit2", commit_cnt, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
